// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if
//   Bundles the two requester ports (instruction fetch "i_*", load/store
//   "d_*") and the single command port toward the SDRAM controller ("m_*").
//
//   Modports:
//     master - the arbiter's view. It takes requests, drives acks and read
//              data back to the core, and masters the controller command port.
//     slave  - the surrounding environment: the core requesters plus the
//              SDRAM controller.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
);
  // fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  // data requester
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0]        d_oplen;
  logic              d_rw;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  // controller command / response
  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [1:0]        m_oplen;
  logic              m_rw;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rsp_valid;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    input  i_req, i_addr,
    input  d_req, d_addr, d_oplen, d_rw, d_wdata,
    input  m_ready, m_rsp_valid, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output m_valid, m_addr, m_oplen, m_rw, m_wdata
  );

  modport slave (
    output i_req, i_addr,
    output d_req, d_addr, d_oplen, d_rw, d_wdata,
    output m_ready, m_rsp_valid, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  m_valid, m_addr, m_oplen, m_rw, m_wdata
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Arbitrates the core's fetch and load/store requesters onto the single
//   SDRAM controller command port. One transaction is in flight at a time:
//   IDLE (grant + latch) -> ISSUE (valid/ready) -> WAIT (response or
//   watchdog) -> ACK (one-cycle ack to the owner).
//   Data has priority, but after DATA_STREAK consecutive data grants taken
//   while fetch was waiting, fetch wins the next arbitration.
//
//   Ports:
//     clk_50      - clock, everything on the rising edge
//     rst_n       - asynchronous active-low reset
//     bus         - sdram_port_arbiter_if.master (requesters + controller)
//     busy        - state is not IDLE
//     owner       - 0 = fetch, 1 = data; current or last grant
//     timeout_err - sticky: set when the watchdog forced a completion
module sdram_port_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 32,
  parameter int DATA_STREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk_50,
  input  logic                rst_n,
  sdram_port_arbiter_if.master bus,
  output logic                busy,
  output logic                owner,
  output logic                timeout_err
);

  localparam int ST_W = $clog2(DATA_STREAK + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(DATA_STREAK);
  // The counter holds the number of WAIT cycles already completed, so the
  // current cycle is the TIMEOUT-th one when it reads TIMEOUT-1.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state_q, state_d;
  logic [ST_W-1:0]   streak_q, streak_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              owner_q, owner_d;
  logic              terr_q, terr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [1:0]        m_oplen_q, m_oplen_d;
  logic              m_rw_q, m_rw_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              grant_data;
  logic              rsp_done;
  logic [DATA_W-1:0] rsp_data;

  // Data wins unless fetch is waiting and data has used up its streak.
  assign grant_data = bus.d_req && !(bus.i_req && (streak_q == ST_MAX));

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      wdog_q    <= '0;
      owner_q   <= 1'b0;
      terr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_oplen_q <= '0;
      m_rw_q    <= 1'b0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      wdog_q    <= wdog_d;
      owner_q   <= owner_d;
      terr_q    <= terr_d;
      m_addr_q  <= m_addr_d;
      m_oplen_q <= m_oplen_d;
      m_rw_q    <= m_rw_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    wdog_d    = wdog_q;
    owner_d   = owner_q;
    terr_d    = terr_q;
    m_addr_d  = m_addr_q;
    m_oplen_d = m_oplen_q;
    m_rw_d    = m_rw_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    rsp_done  = 1'b0;
    rsp_data  = '0;

    case (state_q)
      IDLE: begin
        if (bus.d_req || bus.i_req) begin
          state_d = ISSUE;
          if (grant_data) begin
            owner_d   = 1'b1;
            m_addr_d  = bus.d_addr;
            m_oplen_d = bus.d_oplen;
            m_rw_d    = bus.d_rw;
            m_wdata_d = bus.d_wdata;
            // Only grants that made fetch wait count toward the streak.
            if (bus.i_req)
              streak_d = (streak_q == ST_MAX) ? ST_MAX : streak_q + 1'b1;
            else
              streak_d = '0;
          end else begin
            owner_d   = 1'b0;
            m_addr_d  = bus.i_addr;
            m_oplen_d = 2'b10;
            m_rw_d    = 1'b0;
            m_wdata_d = '0;
            streak_d  = '0;
          end
        end
      end
      ISSUE: begin
        if (bus.m_ready) begin
          state_d = WAIT;
          wdog_d  = '0;
        end
      end
      WAIT: begin
        // A real response wins over an expiry in the same cycle.
        rsp_done = bus.m_rsp_valid || (wdog_q == WD_LAST);
        rsp_data = bus.m_rsp_valid ? bus.m_rdata : '0;
        if (rsp_done) begin
          state_d = ACK;
          if (!bus.m_rsp_valid) terr_d = 1'b1;
          if (!owner_q)     i_rdata_d = rsp_data;
          else if (!m_rw_q) d_rdata_d = rsp_data;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_valid = (state_q == ISSUE);
  assign bus.m_addr  = m_addr_q;
  assign bus.m_oplen = m_oplen_q;
  assign bus.m_rw    = m_rw_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_ack   = (state_q == ACK) && !owner_q;
  assign bus.d_ack   = (state_q == ACK) && owner_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign busy        = (state_q != IDLE);
  assign owner       = owner_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//   Directed bench for sdram_port_arbiter: reset state, fetch read, data
//   write under backpressure, fetch/data contention with streak limit,
//   watchdog expiry and late response, async reset mid-transaction and
//   back-to-back fetch cadence.
module tb_sdram_port_arbiter;
  localparam int ADDR_W      = 25;
  localparam int DATA_W      = 32;
  localparam int DATA_STREAK = 4;
  localparam int TIMEOUT     = 255;

  logic clk_50;
  logic rst_n;
  logic busy;
  logic owner;
  logic timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .DATA_STREAK(DATA_STREAK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_50(clk_50), .rst_n(rst_n), .bus(bus),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  // Starts in an IDLE cycle with the request already presented and
  // m_ready=1; models a 1-cycle controller; ends in the following IDLE cycle.
  task automatic run_txn(input string tag, input bit exp_own,
                         input logic [ADDR_W-1:0] exp_addr,
                         input logic [DATA_W-1:0] rd,
                         output int unsigned ack_cyc);
    tick();
    chk({tag, "_valid"}, bus.m_valid, 1);
    chk({tag, "_owner"}, owner, exp_own);
    chk({tag, "_addr"}, bus.m_addr, exp_addr);
    tick();
    bus.m_rsp_valid = 1'b1;
    bus.m_rdata     = rd;
    tick();
    bus.m_rsp_valid = 1'b0;
    ack_cyc = cyc;
    if (exp_own) begin
      chk({tag, "_dack"}, bus.d_ack, 1);
      chk({tag, "_iack"}, bus.i_ack, 0);
      chk({tag, "_drdata"}, bus.d_rdata, rd);
    end else begin
      chk({tag, "_iack"}, bus.i_ack, 1);
      chk({tag, "_dack"}, bus.d_ack, 0);
      chk({tag, "_irdata"}, bus.i_rdata, rd);
    end
    tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int unsigned ac;
    int unsigned prev;
    int n;

    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_addr = '0; bus.d_oplen = '0; bus.d_rw = 1'b0; bus.d_wdata = '0;
    bus.m_ready = 1'b0; bus.m_rsp_valid = 1'b0; bus.m_rdata = '0;
    repeat (3) @(posedge clk_50);
    #1;

    // reset state
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_iack", bus.i_ack, 0);
    chk("rst_dack", bus.d_ack, 0);
    chk("rst_irdata", bus.i_rdata, 0);
    chk("rst_drdata", bus.d_rdata, 0);
    chk("rst_maddr", bus.m_addr, 0);
    rst_n = 1'b1;

    // fetch read
    bus.i_addr = 25'h000008; bus.i_req = 1'b1; bus.m_ready = 1'b1;
    tick();
    chk("fr_valid", bus.m_valid, 1);
    chk("fr_addr", bus.m_addr, 25'h8);
    chk("fr_rw", bus.m_rw, 0);
    chk("fr_oplen", bus.m_oplen, 2);
    chk("fr_owner", owner, 0);
    chk("fr_busy", busy, 1);
    tick();
    chk("fr_valid_drop", bus.m_valid, 0);
    bus.m_rsp_valid = 1'b1; bus.m_rdata = 32'h00A00093;
    tick();
    chk("fr_iack", bus.i_ack, 1);
    chk("fr_dack", bus.d_ack, 0);
    chk("fr_irdata", bus.i_rdata, 32'h00A00093);
    bus.m_rsp_valid = 1'b0; bus.i_req = 1'b0;
    tick();
    chk("fr_iack_end", bus.i_ack, 0);
    chk("fr_idle", busy, 0);

    // data write with backpressure
    bus.d_req = 1'b1; bus.d_rw = 1'b1; bus.d_wdata = 32'hFEEF;
    bus.d_addr = 25'h123; bus.d_oplen = 2'b01; bus.m_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("wr_valid", bus.m_valid, 1);
      chk("wr_addr", bus.m_addr, 25'h123);
      chk("wr_wdata", bus.m_wdata, 32'hFEEF);
      chk("wr_rw", bus.m_rw, 1);
      chk("wr_oplen", bus.m_oplen, 1);
      chk("wr_owner", owner, 1);
    end
    bus.m_ready = 1'b1;
    tick();
    chk("wr_valid_drop", bus.m_valid, 0);
    chk("wr_dack_early", bus.d_ack, 0);
    bus.m_rsp_valid = 1'b1; bus.m_rdata = 32'hDEADBEEF;
    tick();
    chk("wr_dack", bus.d_ack, 1);
    chk("wr_iack", bus.i_ack, 0);
    chk("wr_drdata", bus.d_rdata, 0);
    bus.m_rsp_valid = 1'b0; bus.d_req = 1'b0;
    tick();
    chk("wr_dack_end", bus.d_ack, 0);
    chk("wr_drdata_end", bus.d_rdata, 0);

    // contention: expect D,D,D,D,I,D,D,D,D,I
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_oplen = 2'b10;
    for (int k = 0; k < 10; k++) begin
      bit eo;
      eo = (k % 5 == 4) ? 1'b0 : 1'b1;
      bus.i_addr = 25'h100 + 25'(k);
      bus.d_addr = 25'h200 + 25'(k);
      run_txn("ct", eo, eo ? 25'h200 + 25'(k) : 25'h100 + 25'(k), 32'h1000 + 32'(k), ac);
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;

    // watchdog: data read, no response
    bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 25'h300;
    tick();
    tick();
    chk("to_err_pre", timeout_err, 0);
    n = 0;
    while (n < 400 && !bus.d_ack) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 255);
    chk("to_dack", bus.d_ack, 1);
    chk("to_drdata", bus.d_rdata, 0);
    chk("to_err", timeout_err, 1);
    bus.d_req = 1'b0;
    tick();
    chk("to_idle", busy, 0);
    bus.m_rsp_valid = 1'b1; bus.m_rdata = 32'h55;
    tick();
    bus.m_rsp_valid = 1'b0;
    chk("late_iack", bus.i_ack, 0);
    chk("late_dack", bus.d_ack, 0);
    chk("late_busy", busy, 0);
    tick();
    chk("late_dack2", bus.d_ack, 0);
    chk("late_terr_sticky", timeout_err, 1);

    // async reset while a command is being offered
    bus.i_req = 1'b1; bus.i_addr = 25'h40; bus.m_ready = 1'b0;
    tick();
    chk("ar_issue_valid", bus.m_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_issue_valid_drop", bus.m_valid, 0);
    chk("ar_issue_busy", busy, 0);
    chk("ar_terr_clear", timeout_err, 0);
    bus.i_req = 1'b0;
    #5 rst_n = 1'b1;

    // async reset mid-WAIT
    bus.i_req = 1'b1; bus.m_ready = 1'b1;
    tick();
    tick();
    chk("ar_wait_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_wait_busy_drop", busy, 0);
    chk("ar_wait_valid", bus.m_valid, 0);
    chk("ar_wait_iack", bus.i_ack, 0);
    chk("ar_wait_dack", bus.d_ack, 0);
    bus.i_req = 1'b0;
    #5 rst_n = 1'b1;
    tick();
    bus.i_addr = 25'h44; bus.i_req = 1'b1;
    run_txn("ar_fresh", 1'b0, 25'h44, 32'hCAFE0001, ac);
    bus.i_req = 1'b0;

    // back-to-back fetch
    bus.i_req = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      bus.i_addr = 25'h80 + 25'(4 * k);
      run_txn("b2b", 1'b0, 25'h80 + 25'(4 * k), 32'h2000 + 32'(k), ac);
      if (k > 0) chk("b2b_period", ac - prev, 4);
      prev = ac;
    end
    bus.i_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
